// File: rtl/object_compositor.sv
// Merges NUM_OBJ prioritised object layers over a background into one registered
// pixel, and accumulates per-frame overlap flags for hit detection.
module object_compositor #(
  parameter int unsigned          NUM_OBJ     = 4,
  parameter int unsigned          RGB_WIDTH   = 8,
  parameter logic [RGB_WIDTH-1:0] TRANSPARENT = 8'hFF
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                startOfFrame,
  input  logic [NUM_OBJ-1:0]                  layer_enable,
  input  logic [0:NUM_OBJ-1]                  draw_requests,
  input  logic [0:NUM_OBJ-1][RGB_WIDTH-1:0]   obj_RGB,
  input  logic [RGB_WIDTH-1:0]                background_RGB,
  output logic [RGB_WIDTH-1:0]                RGBout,
  output logic [$clog2(NUM_OBJ):0]            active_layer,
  output logic [NUM_OBJ-1:0]                  collision,
  output logic                                collision_valid
);

  localparam int unsigned AW = $clog2(NUM_OBJ) + 1;

  logic [NUM_OBJ-1:0]   active;
  logic [NUM_OBJ-1:0]   overlap;
  logic [NUM_OBJ-1:0]   hit_acc;
  logic [RGB_WIDTH-1:0] rgb_next;
  logic [AW-1:0]        layer_next;

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      active[i] = draw_requests[i] & layer_enable[i] & (obj_RGB[i] != TRANSPARENT);
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something behind.
  always_comb begin
    overlap = '0;
    if ((active & (active - NUM_OBJ'(1))) != '0) begin
      overlap = active;
    end
  end

  // Scan from the lowest-priority end so the lowest active index wins.
  always_comb begin
    rgb_next   = background_RGB;
    layer_next = AW'(NUM_OBJ);
    for (int unsigned i = NUM_OBJ; i > 0; i--) begin
      if (active[i-1]) begin
        rgb_next   = obj_RGB[i-1];
        layer_next = AW'(i-1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBout       <= '0;
      active_layer <= AW'(NUM_OBJ);
    end else begin
      RGBout       <= rgb_next;
      active_layer <= layer_next;
    end
  end

  // The frame-boundary pixel is folded into the closing frame's report.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_acc         <= '0;
      collision       <= '0;
      collision_valid <= 1'b0;
    end else if (startOfFrame) begin
      collision       <= hit_acc | overlap;
      collision_valid <= 1'b1;
      hit_acc         <= '0;
    end else begin
      hit_acc         <= hit_acc | overlap;
      collision_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_object_compositor.sv
// Directed self-checking bench for object_compositor (NUM_OBJ=4, RGB_WIDTH=8).
module tb_object_compositor;

  logic             clk;
  logic             resetN;
  logic             startOfFrame;
  logic [3:0]       layer_enable;
  logic [0:3]       draw_requests;
  logic [0:3][7:0]  obj_RGB;
  logic [7:0]       background_RGB;
  logic [7:0]       RGBout;
  logic [2:0]       active_layer;
  logic [3:0]       collision;
  logic             collision_valid;

  int errors = 0;
  int checks = 0;

  object_compositor #(
    .NUM_OBJ    (4),
    .RGB_WIDTH  (8),
    .TRANSPARENT(8'hFF)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .layer_enable   (layer_enable),
    .draw_requests  (draw_requests),
    .obj_RGB        (obj_RGB),
    .background_RGB (background_RGB),
    .RGBout         (RGBout),
    .active_layer   (active_layer),
    .collision      (collision),
    .collision_valid(collision_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    startOfFrame   = 1'b0;
    layer_enable   = 4'b1111;
    draw_requests  = 4'b0000;
    obj_RGB        = {8'h11, 8'h22, 8'h33, 8'h44};
    background_RGB = 8'h55;
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    set_idle();
    #2 resetN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      startOfFrame   = 1'($urandom);
      layer_enable   = 4'($urandom);
      draw_requests  = 4'($urandom);
      obj_RGB        = 32'($urandom);
      background_RGB = 8'($urandom);
      step();
      checks++; if (RGBout !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %h want 00", RGBout); end
      checks++; if (active_layer !== 3'd4) begin errors++; $display("FAIL reset_layer: got %0d want 4", active_layer); end
      checks++; if (collision !== 4'b0000) begin errors++; $display("FAIL reset_collision: got %b want 0000", collision); end
      checks++; if (collision_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", collision_valid); end
    end
    set_idle();
    resetN = 1'b1;
    step();
  endtask

  task automatic test_priority();
    draw_requests = 4'b0110;
    step();
    checks++; if (RGBout !== 8'h22) begin errors++; $display("FAIL prio_rgb: got %h want 22", RGBout); end
    checks++; if (active_layer !== 3'd1) begin errors++; $display("FAIL prio_layer: got %0d want 1", active_layer); end
    draw_requests = 4'b0001;
    step();
    checks++; if (RGBout !== 8'h44) begin errors++; $display("FAIL prio_low_rgb: got %h want 44", RGBout); end
    checks++; if (active_layer !== 3'd3) begin errors++; $display("FAIL prio_low_layer: got %0d want 3", active_layer); end
    draw_requests = 4'b0000;
    step();
    checks++; if (RGBout !== 8'h55) begin errors++; $display("FAIL prio_bg_rgb: got %h want 55", RGBout); end
    checks++; if (active_layer !== 3'd4) begin errors++; $display("FAIL prio_bg_layer: got %0d want 4", active_layer); end
    // layers 1 and 2 overlapped above; the single layer-3 cycle adds nothing
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    checks++; if (collision !== 4'b0110) begin errors++; $display("FAIL prio_collision: got %b want 0110", collision); end
    checks++; if (collision_valid !== 1'b1) begin errors++; $display("FAIL prio_valid: got %b want 1", collision_valid); end
    step();
    checks++; if (collision_valid !== 1'b0) begin errors++; $display("FAIL prio_valid_drop: got %b want 0", collision_valid); end
  endtask

  task automatic test_mask();
    draw_requests = 4'b1100;
    obj_RGB[0]    = 8'hFF;
    layer_enable  = 4'b1101;
    step();
    checks++; if (RGBout !== 8'h55) begin errors++; $display("FAIL mask_rgb: got %h want 55", RGBout); end
    checks++; if (active_layer !== 3'd4) begin errors++; $display("FAIL mask_layer: got %0d want 4", active_layer); end
    obj_RGB[0] = 8'h11;
    step();
    checks++; if (RGBout !== 8'h11) begin errors++; $display("FAIL mask_l0_rgb: got %h want 11", RGBout); end
    checks++; if (active_layer !== 3'd0) begin errors++; $display("FAIL mask_l0_layer: got %0d want 0", active_layer); end
    set_idle();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    checks++; if (collision !== 4'b0000) begin errors++; $display("FAIL mask_collision: got %b want 0000", collision); end
    checks++; if (collision_valid !== 1'b1) begin errors++; $display("FAIL mask_valid: got %b want 1", collision_valid); end
  endtask

  task automatic test_collision();
    draw_requests = 4'b1010;
    step();
    draw_requests = 4'b0000;
    step();
    step();
    checks++; if (collision_valid !== 1'b0) begin errors++; $display("FAIL coll_idle_valid: got %b want 0", collision_valid); end
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    checks++; if (collision !== 4'b0101) begin errors++; $display("FAIL coll_flags: got %b want 0101", collision); end
    checks++; if (collision_valid !== 1'b1) begin errors++; $display("FAIL coll_valid: got %b want 1", collision_valid); end
    step();
    checks++; if (collision_valid !== 1'b0) begin errors++; $display("FAIL coll_valid_drop: got %b want 0", collision_valid); end
    checks++; if (collision !== 4'b0101) begin errors++; $display("FAIL coll_hold: got %b want 0101", collision); end
    step();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    checks++; if (collision !== 4'b0000) begin errors++; $display("FAIL coll_next_frame: got %b want 0000", collision); end
  endtask

  task automatic test_boundary();
    draw_requests = 4'b0101;
    startOfFrame  = 1'b1;
    step();
    draw_requests = 4'b0000;
    startOfFrame  = 1'b0;
    checks++; if (collision !== 4'b1010) begin errors++; $display("FAIL bnd_flags: got %b want 1010", collision); end
    checks++; if (RGBout !== 8'h22) begin errors++; $display("FAIL bnd_rgb: got %h want 22", RGBout); end
    step();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    checks++; if (collision !== 4'b0000) begin errors++; $display("FAIL bnd_next_frame: got %b want 0000", collision); end
  endtask

  task automatic test_back_to_back();
    draw_requests = 4'b0011;
    step();
    draw_requests = 4'b0000;
    startOfFrame  = 1'b1;
    step();
    checks++; if (collision !== 4'b1100) begin errors++; $display("FAIL b2b_first: got %b want 1100", collision); end
    draw_requests = 4'b1100;
    step();
    draw_requests = 4'b0000;
    startOfFrame  = 1'b0;
    checks++; if (collision !== 4'b0011) begin errors++; $display("FAIL b2b_second: got %b want 0011", collision); end
    checks++; if (collision_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", collision_valid); end
    step();
    checks++; if (collision_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b want 0", collision_valid); end
  endtask

  task automatic test_async_reset();
    draw_requests = 4'b1010;
    step();
    draw_requests = 4'b0000;
    checks++; if (RGBout !== 8'h11) begin errors++; $display("FAIL ar_pre_rgb: got %h want 11", RGBout); end
    #1 resetN = 1'b0;
    #1;
    checks++; if (RGBout !== 8'h00) begin errors++; $display("FAIL ar_rgb: got %h want 00", RGBout); end
    checks++; if (active_layer !== 3'd4) begin errors++; $display("FAIL ar_layer: got %0d want 4", active_layer); end
    resetN = 1'b1;
    step();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    checks++; if (collision !== 4'b0000) begin errors++; $display("FAIL ar_collision: got %b want 0000", collision); end
    draw_requests = 4'b0101;
    step();
    draw_requests = 4'b0000;
    startOfFrame  = 1'b1;
    step();
    startOfFrame = 1'b0;
    checks++; if (collision !== 4'b1010) begin errors++; $display("FAIL ar_post_flags: got %b want 1010", collision); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_mask();
    test_collision();
    test_boundary();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
